mem_access_seq: RTL and testbench

Multi-cycle sequencer for data-memory accesses in the MEM stage. Takes the decoded `memwrite`/`memtoreg`/`memsize` controls plus address and store data, and runs one or two word-aligned transactions on a req/ack data bus. Misaligned accesses are split across two words. Load results are sign- or zero-extended, and the pipeline is stalled until the access completes.

---
 rtl/mem_access_seq_if.sv | 26 ++
 rtl/mem_access_seq.sv | 201 ++++++++++++++++++++
 tb/tb_mem_access_seq.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_seq_if
// Brief    : Word-aligned req/ack data-bus bundle for the MEM-stage sequencer.
// Revision : 1.0
// ============================================================================
interface mem_access_seq_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_seq.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_seq
// Brief    : MEM-stage load/store sequencer; splits misaligned accesses into
//            two bus words, extends load data and stalls until completion.
// Revision : 1.0
// ============================================================================
module mem_access_seq #(
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              memwrite,
  input  logic              memtoreg,
  input  logic [2:0]        memsize,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic              done,
  output logic              fault,
  output logic [31:0]       rdata,
  mem_access_seq_if.master  bus
);

  localparam int c_CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ0 = 2'd1,
    S_REQ1 = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [c_CNT_W-1:0] r_cnt;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;
  logic [2:0]         r_size;
  logic               r_we;
  logic               r_fault;
  logic [63:0]        r_buf;

  logic        w_accept;
  logic        w_legal_ld;
  logic        w_legal_st;
  logic        w_illegal;
  logic [1:0]  w_off;
  logic [2:0]  w_nbytes;
  logic [7:0]  w_mask8;
  logic        w_cross;
  logic [63:0] w_lane;
  logic        w_tmo;
  logic [31:0] w_word;
  logic [31:0] w_ext;
  logic [31:0] w_base;

  assign w_accept = start && (memwrite || memtoreg);

  always_comb begin
    w_legal_ld = 1'b0;
    w_legal_st = 1'b0;
    case (memsize)
      3'b000, 3'b001, 3'b010: begin
        w_legal_ld = 1'b1;
        w_legal_st = 1'b1;
      end
      3'b100, 3'b101: w_legal_ld = 1'b1;
      default: ;
    endcase
  end

  assign w_illegal = (memwrite && memtoreg) || (memwrite ? !w_legal_st : !w_legal_ld);

  assign w_off = r_addr[1:0];

  always_comb begin
    case (r_size[1:0])
      2'b00:   w_nbytes = 3'd1;
      2'b01:   w_nbytes = 3'd2;
      default: w_nbytes = 3'd4;
    endcase
  end

  assign w_mask8 = ((8'd1 << w_nbytes) - 8'd1) << w_off;
  assign w_cross = ({2'b00, w_off} + {1'b0, w_nbytes}) > 4'd4;
  assign w_lane  = {32'd0, r_wdata} << {w_off, 3'b000};
  assign w_tmo   = (r_cnt == c_CNT_W'(TIMEOUT - 1));
  assign w_base  = {r_addr[31:2], 2'b00};

  // Load data sits in the two-word buffer starting at the byte offset.
  assign w_word = r_buf[{w_off, 3'b000} +: 32];

  always_comb begin
    case (r_size)
      3'b000:  w_ext = {{24{w_word[7]}}, w_word[7:0]};
      3'b001:  w_ext = {{16{w_word[15]}}, w_word[15:0]};
      3'b100:  w_ext = {24'd0, w_word[7:0]};
      3'b101:  w_ext = {16'd0, w_word[15:0]};
      default: w_ext = w_word;
    endcase
  end

  always_comb begin
    w_next        = r_state;
    stall         = 1'b0;
    done          = 1'b0;
    fault         = 1'b0;
    rdata         = 32'd0;
    bus.bus_req   = 1'b0;
    bus.bus_we    = 1'b0;
    bus.bus_addr  = 32'd0;
    bus.bus_be    = 4'd0;
    bus.bus_wdata = 32'd0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          stall  = 1'b1;
          w_next = w_illegal ? S_DONE : S_REQ0;
        end
      end
      S_REQ0: begin
        stall         = 1'b1;
        bus.bus_req   = 1'b1;
        bus.bus_we    = r_we;
        bus.bus_addr  = w_base;
        bus.bus_be    = w_mask8[3:0];
        bus.bus_wdata = w_lane[31:0];
        if (bus.bus_ack) begin
          w_next = w_cross ? S_REQ1 : S_DONE;
        end else if (w_tmo) begin
          w_next = S_DONE;
        end
      end
      S_REQ1: begin
        stall         = 1'b1;
        bus.bus_req   = 1'b1;
        bus.bus_we    = r_we;
        bus.bus_addr  = w_base + 32'd4;
        bus.bus_be    = w_mask8[7:4];
        bus.bus_wdata = w_lane[63:32];
        if (bus.bus_ack || w_tmo) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        done   = 1'b1;
        fault  = r_fault;
        rdata  = (!r_we && !r_fault) ? w_ext : 32'd0;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_buf   <= 64'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_size  <= 3'd0;
      r_we    <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr  <= addr;
            r_wdata <= wdata;
            r_size  <= memsize;
            r_we    <= memwrite;
            r_fault <= w_illegal;
            r_cnt   <= '0;
          end
        end
        S_REQ0, S_REQ1: begin
          if (bus.bus_ack) begin
            r_cnt <= '0;
            if (r_state == S_REQ0) begin
              r_buf[31:0] <= bus.bus_rdata;
            end else begin
              r_buf[63:32] <= bus.bus_rdata;
            end
          end else if (w_tmo) begin
            r_fault <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_seq
// Brief    : Directed vector bench for mem_access_seq with a wait-state slave.
// Revision : 1.0
// ============================================================================
module tb_mem_access_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        memwrite;
  logic        memtoreg;
  logic [2:0]  memsize;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        done;
  logic        fault;
  logic [31:0] rdata;

  int n_chk;
  int n_fail;

  mem_access_seq_if bus_if ();

  mem_access_seq #(.TIMEOUT(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .memwrite (memwrite),
    .memtoreg (memtoreg),
    .memsize  (memsize),
    .addr     (addr),
    .wdata    (wdata),
    .stall    (stall),
    .done     (done),
    .fault    (fault),
    .rdata    (rdata),
    .bus      (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        ld;
    logic [2:0]  sz;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd0;
    logic [31:0] rd1;
    int          waits;
    logic [31:0] e_rd;
    logic        e_f;
    int          e_lat;
    int          e_ntx;
    logic [31:0] e_a0;
    logic [3:0]  e_be0;
    logic [31:0] e_wd0;
    logic [31:0] e_a1;
    logic [3:0]  e_be1;
    logic [31:0] e_wd1;
  } vec_t;

  vec_t vecs [14];
  vec_t v_post;

  function automatic vec_t mkv(
    input logic we, input logic ld, input logic [2:0] sz,
    input logic [31:0] a, input logic [31:0] wd,
    input logic [31:0] rd0, input logic [31:0] rd1, input int waits,
    input logic [31:0] e_rd, input logic e_f, input int e_lat, input int e_ntx,
    input logic [31:0] e_a0, input logic [3:0] e_be0, input logic [31:0] e_wd0,
    input logic [31:0] e_a1, input logic [3:0] e_be1, input logic [31:0] e_wd1);
    vec_t v;
    v.we = we; v.ld = ld; v.sz = sz; v.a = a; v.wd = wd;
    v.rd0 = rd0; v.rd1 = rd1; v.waits = waits;
    v.e_rd = e_rd; v.e_f = e_f; v.e_lat = e_lat; v.e_ntx = e_ntx;
    v.e_a0 = e_a0; v.e_be0 = e_be0; v.e_wd0 = e_wd0;
    v.e_a1 = e_a1; v.e_be1 = e_be1; v.e_wd1 = e_wd1;
    return v;
  endfunction

  task automatic chk(input string what, input int vi, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (vec %0d): got %h expected %h", what, vi, act, exp);
    end
  endtask

  // One access: accept in cycle 0, slave acks each word after v.waits wait cycles.
  task automatic run_vec(input vec_t v, input int vi);
    int          lat;
    int          idx;
    int          waited;
    int          n_stall;
    int          ntx;
    logic        new_tx;
    logic [31:0] got_rd;
    logic        got_f;
    logic [31:0] ra [2];
    logic [3:0]  rb [2];
    logic [31:0] rw [2];
    logic        rwe [2];
    lat = -1; idx = 0; waited = 0; n_stall = 0; ntx = 0; new_tx = 1'b1;
    got_rd = 32'd0; got_f = 1'b0;
    for (int k = 0; k < 2; k++) begin
      ra[k] = 32'd0; rb[k] = 4'd0; rw[k] = 32'd0; rwe[k] = 1'b0;
    end
    for (int cyc = 0; cyc < 40 && lat < 0; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        start = 1'b1; memwrite = v.we; memtoreg = v.ld; memsize = v.sz;
        addr = v.a; wdata = v.wd;
      end else begin
        start = 1'b0; memwrite = 1'b0; memtoreg = 1'b0; memsize = 3'b111;
        addr = 32'hCAFE_F00D; wdata = 32'h5555_AAAA;
      end
      bus_if.bus_ack   = 1'b0;
      bus_if.bus_rdata = 32'hA5A5_A5A5;
      if (bus_if.bus_req) begin
        if (new_tx) begin
          ntx++;
          if (idx < 2) begin
            ra[idx] = bus_if.bus_addr; rb[idx] = bus_if.bus_be;
            rw[idx] = bus_if.bus_wdata; rwe[idx] = bus_if.bus_we;
          end
          new_tx = 1'b0;
        end else if (idx < 2) begin
          chk("bus_stable", vi, {bus_if.bus_addr ^ ra[idx]} | {bus_if.bus_wdata ^ rw[idx]}
              | {27'd0, bus_if.bus_we ^ rwe[idx], bus_if.bus_be ^ rb[idx]}, 32'd0);
        end
        if (waited == v.waits) begin
          bus_if.bus_ack   = 1'b1;
          bus_if.bus_rdata = (idx == 0) ? v.rd0 : v.rd1;
          idx++; waited = 0; new_tx = 1'b1;
        end else begin
          waited++;
        end
      end else begin
        chk("idle_be_we", vi, {27'd0, bus_if.bus_we, bus_if.bus_be}, 32'd0);
      end
      #1;
      if (cyc == 0) chk("done_low_at_accept", vi, {31'd0, done}, 32'd0);
      if (stall) n_stall++;
      if (done) begin
        lat = cyc; got_rd = rdata; got_f = fault;
      end
    end
    bus_if.bus_ack = 1'b0;
    chk("latency", vi, 32'(lat), 32'(v.e_lat));
    chk("stall_cycles", vi, 32'(n_stall), 32'(v.e_lat));
    chk("fault", vi, {31'd0, got_f}, {31'd0, v.e_f});
    chk("rdata", vi, got_rd, v.e_rd);
    chk("n_transactions", vi, 32'(ntx), 32'(v.e_ntx));
    if (v.e_ntx >= 1) begin
      chk("addr0", vi, ra[0], v.e_a0);
      chk("be0", vi, {28'd0, rb[0]}, {28'd0, v.e_be0});
      chk("wdata0", vi, rw[0], v.e_wd0);
      chk("we0", vi, {31'd0, rwe[0]}, {31'd0, v.we});
    end
    if (v.e_ntx >= 2) begin
      chk("addr1", vi, ra[1], v.e_a1);
      chk("be1", vi, {28'd0, rb[1]}, {28'd0, v.e_be1});
      chk("wdata1", vi, rw[1], v.e_wd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int saw_done;
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; start = 1'b0; memwrite = 1'b0; memtoreg = 1'b0;
    memsize = 3'd0; addr = 32'd0; wdata = 32'd0;
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'd0;

    //            we  ld  sz      addr          wdata         rd0           rd1           w   e_rd          f  lat ntx a0            be0   wd0           a1            be1   wd1
    vecs[0]  = mkv(0, 1, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 32'h0,       0,  32'hDEAD_BEEF, 0, 2, 1, 32'h0000_0100, 4'hF, 32'h0,        32'h0,        4'h0, 32'h0);
    vecs[1]  = mkv(0, 1, 3'b000, 32'h0000_0103, 32'h0,        32'h8012_3456, 32'h0,       0,  32'hFFFF_FF80, 0, 2, 1, 32'h0000_0100, 4'h8, 32'h0,        32'h0,        4'h0, 32'h0);
    vecs[2]  = mkv(0, 1, 3'b100, 32'h0000_0103, 32'h0,        32'h8012_3456, 32'h0,       0,  32'h0000_0080, 0, 2, 1, 32'h0000_0100, 4'h8, 32'h0,        32'h0,        4'h0, 32'h0);
    vecs[3]  = mkv(1, 0, 3'b001, 32'h0000_1003, 32'h0000_ABCD, 32'h1111_1111, 32'h2222_2222, 2, 32'h0,     0, 7, 2, 32'h0000_1000, 4'h8, 32'hCD00_0000, 32'h0000_1004, 4'h1, 32'h0000_00AB);
    vecs[4]  = mkv(0, 1, 3'b010, 32'hFFFF_FFFE, 32'h0,        32'h1122_AAAA, 32'hBBBB_3344, 0, 32'h3344_1122, 0, 3, 2, 32'hFFFF_FFFC, 4'hC, 32'h0,     32'h0000_0000, 4'h3, 32'h0);
    vecs[5]  = mkv(0, 1, 3'b001, 32'h0000_0202, 32'h0,        32'h8001_0000, 32'h0,       0,  32'hFFFF_8001, 0, 2, 1, 32'h0000_0200, 4'hC, 32'h0,        32'h0,        4'h0, 32'h0);
    vecs[6]  = mkv(0, 1, 3'b101, 32'h0000_0201, 32'h0,        32'h12AB_CD34, 32'h0,       0,  32'h0000_ABCD, 0, 2, 1, 32'h0000_0200, 4'h6, 32'h0,        32'h0,        4'h0, 32'h0);
    vecs[7]  = mkv(1, 0, 3'b000, 32'h0000_0302, 32'hFFFF_FF5A, 32'hFFFF_FFFF, 32'h0,     1,  32'h0,         0, 3, 1, 32'h0000_0300, 4'h4, 32'hFF5A_0000, 32'h0,        4'h0, 32'h0);
    vecs[8]  = mkv(1, 0, 3'b010, 32'h0000_0400, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0,     0,  32'h0,         0, 2, 1, 32'h0000_0400, 4'hF, 32'h1234_5678, 32'h0,        4'h0, 32'h0);
    vecs[9]  = mkv(0, 1, 3'b010, 32'h0000_0105, 32'h0,        32'hAABB_CCDD, 32'h1122_3344, 1, 32'h44AA_BBCC, 0, 5, 2, 32'h0000_0104, 4'hE, 32'h0,     32'h0000_0108, 4'h1, 32'h0);
    vecs[10] = mkv(0, 1, 3'b011, 32'h0000_0100, 32'h0,        32'h0,         32'h0,       0,  32'h0,         1, 1, 0, 32'h0,        4'h0, 32'h0,        32'h0,        4'h0, 32'h0);
    vecs[11] = mkv(1, 1, 3'b010, 32'h0000_0100, 32'h0,        32'h0,         32'h0,       0,  32'h0,         1, 1, 0, 32'h0,        4'h0, 32'h0,        32'h0,        4'h0, 32'h0);
    vecs[12] = mkv(1, 0, 3'b100, 32'h0000_0100, 32'h0,        32'h0,         32'h0,       0,  32'h0,         1, 1, 0, 32'h0,        4'h0, 32'h0,        32'h0,        4'h0, 32'h0);
    vecs[13] = mkv(0, 1, 3'b010, 32'h0000_0500, 32'h0,        32'h7777_7777, 32'h0,       99, 32'h0,         1, 5, 1, 32'h0000_0500, 4'hF, 32'h0,        32'h0,        4'h0, 32'h0);
    v_post   = mkv(1, 0, 3'b010, 32'h0000_0800, 32'h0BAD_F00D, 32'h0,        32'h0,       0,  32'h0,         0, 2, 1, 32'h0000_0800, 4'hF, 32'h0BAD_F00D, 32'h0,        4'h0, 32'h0);

    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", -1, {26'd0, stall, done, fault, bus_if.bus_req, bus_if.bus_we, |bus_if.bus_be} | rdata
        | bus_if.bus_addr | bus_if.bus_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_reset_idle", -1, {28'd0, stall, done, fault, bus_if.bus_req}, 32'd0);

    for (int i = 0; i < 14; i++) begin
      run_vec(vecs[i], i);
    end

    // Reset while the second word of a crossing load is outstanding.
    @(negedge clk);
    start = 1'b1; memwrite = 1'b0; memtoreg = 1'b1; memsize = 3'b010;
    addr = 32'h0000_07FE; wdata = 32'd0;
    @(negedge clk);
    start = 1'b0; memtoreg = 1'b0;
    chk("rst_req0", 100, {31'd0, bus_if.bus_req}, 32'd1);
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h1234_0000;
    @(negedge clk);
    bus_if.bus_ack = 1'b0;
    chk("rst_req1_addr", 100, bus_if.bus_addr, 32'h0000_0800);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_drop", 100, {29'd0, bus_if.bus_req, stall, done}, 32'd0);
    saw_done = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      if (done) saw_done = 1;
    end
    chk("rst_no_done", 100, 32'(saw_done), 32'd0);
    run_vec(v_post, 101);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
